// File: rtl/bdc_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bdc_frame_ctrl
// Brief    : Frame-level controller and configuration sequencer for the
//            barrel-distortion corrector. Software-written shadow config is
//            committed to active_* only on an accepted start-of-frame beat.
//            The corrector's s_axis handshake is tapped to count pixels and
//            lines, flag malformed frames and raise a level interrupt.
// Options  : define BDC_FRAME_TIMEOUT_EN to add the mid-frame stall timeout.
// Revision : 1.0 - initial release
// ============================================================================
module bdc_frame_ctrl #(
    parameter int          WIDTH          = 1920,
    parameter int          HEIGHT         = 1080,
    parameter int          COORD_WIDTH    = 16,
    parameter logic [15:0] DEF_K1         = 16'h0200,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_wr_en,
    input  logic                   cfg_rd_en,
    input  logic [2:0]             cfg_addr,
    input  logic [31:0]            cfg_wdata,
    output logic [31:0]            cfg_rdata,
    output logic                   cfg_rd_valid,
    input  logic                   mon_tvalid,
    input  logic                   mon_tready,
    input  logic                   mon_tlast,
    input  logic                   mon_tuser,
    output logic [15:0]            active_k1,
    output logic [COORD_WIDTH-1:0] active_cx,
    output logic [COORD_WIDTH-1:0] active_cy,
    output logic                   active_bypass,
    output logic                   core_enable,
    output logic [31:0]            frame_cnt,
    output logic                   irq
);

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_K1     = 3'd1;
    localparam logic [2:0] A_CENTER = 3'd2;
    localparam logic [2:0] A_STATUS = 3'd3;
    localparam logic [2:0] A_FCNT   = 3'd4;
    localparam logic [2:0] A_IRQEN  = 3'd5;

    localparam logic [1:0] S_DISABLED = 2'd0;
    localparam logic [1:0] S_ARMED    = 2'd1;
    localparam logic [1:0] S_IN_FRAME = 2'd2;

    localparam int F_SHORT_LINE  = 0;
    localparam int F_LONG_LINE   = 1;
    localparam int F_SHORT_FRAME = 2;
    localparam int F_LONG_FRAME  = 3;
    localparam int F_FRAME_DONE  = 4;
    localparam int F_TIMEOUT     = 5;

    localparam logic [COORD_WIDTH-1:0] X_LAST = COORD_WIDTH'(WIDTH - 1);
    localparam logic [COORD_WIDTH-1:0] Y_LAST = COORD_WIDTH'(HEIGHT - 1);
    localparam logic [COORD_WIDTH-1:0] CX_RST = COORD_WIDTH'(WIDTH / 2);
    localparam logic [COORD_WIDTH-1:0] CY_RST = COORD_WIDTH'(HEIGHT / 2);

    logic [1:0]             state_q, state_d;
    logic [COORD_WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic                   en_q, byp_q;
    logic [15:0]            k1_q;
    logic [COORD_WIDTH-1:0] cx_q, cy_q;
    logic [5:0]             status_q, status_d;
    logic [5:0]             irq_en_q;
    logic [31:0]            frame_cnt_q;
    logic [15:0]            act_k1_q;
    logic [COORD_WIDTH-1:0] act_cx_q, act_cy_q;
    logic                   act_byp_q;
    logic                   irq_q;
    logic [31:0]            rdata_q, rdata_d;
    logic                   rd_valid_q;

    logic       w_beat, w_sof, w_commit, w_frame_inc, w_clr_cnt;
    logic [5:0] w_set;

    assign w_beat    = mon_tvalid & mon_tready;
    assign w_sof     = w_beat & mon_tuser;
    assign w_clr_cnt = cfg_wr_en & (cfg_addr == A_CTRL) & cfg_wdata[2];

`ifdef BDC_FRAME_TIMEOUT_EN
    localparam int                 STALL_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 1);
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               w_stall_hit;

    assign w_stall_hit = (stall_q == STALL_LAST);

    // Stall counter: counts beat-less cycles inside a frame, cleared otherwise
    always_comb begin
        stall_d = '0;
        if (state_q == S_IN_FRAME && !w_beat && !w_stall_hit)
            stall_d = stall_q + STALL_W'(1);
    end

    // Stall counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_q <= '0;
        else        stall_q <= stall_d;
    end
`endif

    // Next-state logic: frame tracking, line/frame error detection, commit
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        w_set       = '0;
        w_commit    = 1'b0;
        w_frame_inc = 1'b0;
        case (state_q)
            S_DISABLED: begin
                if (en_q) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (!en_q) begin
                    state_d = S_DISABLED;
                end else if (w_sof) begin
                    w_commit = 1'b1;
                    x_d      = COORD_WIDTH'(1);
                    y_d      = '0;
                    state_d  = S_IN_FRAME;
                end else if (w_beat) begin
                    // Pixels outside any frame: previous frame ran long
                    w_set[F_LONG_FRAME] = 1'b1;
                end
            end
            S_IN_FRAME: begin
                if (w_sof) begin
                    // New frame before the old one finished: restart on it
                    w_set[F_SHORT_FRAME] = 1'b1;
                    w_commit             = 1'b1;
                    x_d                  = COORD_WIDTH'(1);
                    y_d                  = '0;
                end else if (w_beat) begin
                    if (mon_tlast || x_q == X_LAST) begin
                        w_set[F_SHORT_LINE] = mon_tlast & (x_q != X_LAST);
                        w_set[F_LONG_LINE]  = ~mon_tlast;
                        x_d                 = '0;
                        y_d                 = y_q + COORD_WIDTH'(1);
                        if (y_q == Y_LAST) begin
                            w_set[F_FRAME_DONE] = 1'b1;
                            w_frame_inc         = 1'b1;
                            y_d                 = '0;
                            state_d             = en_q ? S_ARMED : S_DISABLED;
                        end
                    end else begin
                        x_d = x_q + COORD_WIDTH'(1);
                    end
                end
`ifdef BDC_FRAME_TIMEOUT_EN
                else if (w_stall_hit) begin
                    w_set[F_TIMEOUT] = 1'b1;
                    state_d          = S_ARMED;
                end
`endif
            end
            default: state_d = S_DISABLED;
        endcase
    end

    // Output logic: the corrector runs whenever the sequencer is not disabled
    always_comb begin
        core_enable = (state_q != S_DISABLED);
    end

    // State register and pixel/line counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_DISABLED;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    // Sticky status: software W1C first, hardware set applied on top so it wins
    always_comb begin
        status_d = status_q;
        if (cfg_wr_en && cfg_addr == A_STATUS)
            status_d = status_q & ~cfg_wdata[5:0];
        status_d = status_d | w_set;
    end

    // Shadow configuration, status, interrupt enable and frame counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q        <= 1'b0;
            byp_q       <= 1'b0;
            k1_q        <= DEF_K1;
            cx_q        <= CX_RST;
            cy_q        <= CY_RST;
            status_q    <= '0;
            irq_en_q    <= '0;
            frame_cnt_q <= '0;
        end else begin
            status_q <= status_d;
            if (cfg_wr_en) begin
                case (cfg_addr)
                    A_CTRL: begin
                        en_q  <= cfg_wdata[0];
                        byp_q <= cfg_wdata[1];
                    end
                    A_K1:     k1_q <= cfg_wdata[15:0];
                    A_CENTER: begin
                        cx_q <= COORD_WIDTH'(cfg_wdata[15:0]);
                        cy_q <= COORD_WIDTH'(cfg_wdata[31:16]);
                    end
                    A_IRQEN:  irq_en_q <= cfg_wdata[5:0];
                    default:  ;
                endcase
            end
            if (w_clr_cnt)        frame_cnt_q <= '0;
            else if (w_frame_inc) frame_cnt_q <= frame_cnt_q + 32'd1;
        end
    end

    // Active configuration: loaded from the shadow only on an accepted SOF
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_k1_q  <= DEF_K1;
            act_cx_q  <= CX_RST;
            act_cy_q  <= CY_RST;
            act_byp_q <= 1'b0;
        end else if (w_commit) begin
            act_k1_q  <= k1_q;
            act_cx_q  <= cx_q;
            act_cy_q  <= cy_q;
            act_byp_q <= byp_q;
        end
    end

    // Register read mux; clr_cnt is self-clearing so it always reads 0
    always_comb begin
        rdata_d = '0;
        case (cfg_addr)
            A_CTRL:   rdata_d = {30'd0, byp_q, en_q};
            A_K1:     rdata_d = {16'd0, k1_q};
            A_CENTER: rdata_d = {16'(cy_q), 16'(cx_q)};
            A_STATUS: rdata_d = {26'd0, status_q};
            A_FCNT:   rdata_d = frame_cnt_q;
            A_IRQEN:  rdata_d = {26'd0, irq_en_q};
            default:  rdata_d = '0;
        endcase
    end

    // Registered read port and level interrupt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            rd_valid_q <= cfg_rd_en;
            if (cfg_rd_en) rdata_q <= rdata_d;
            irq_q <= |(status_q & irq_en_q);
        end
    end

    assign cfg_rdata     = rdata_q;
    assign cfg_rd_valid  = rd_valid_q;
    assign active_k1     = act_k1_q;
    assign active_cx     = act_cx_q;
    assign active_cy     = act_cy_q;
    assign active_bypass = act_byp_q;
    assign frame_cnt     = frame_cnt_q;
    assign irq           = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_bdc_frame_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_bdc_frame_ctrl
// Brief    : Self-checking bench for bdc_frame_ctrl. Frames are described as
//            lists of lines (length, tlast present) and the expected status,
//            frame count and committed config are derived from that list.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bdc_frame_ctrl;

    localparam int W  = 12;
    localparam int H  = 5;
    localparam int TO = 64;

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_K1     = 3'd1;
    localparam logic [2:0] A_CENTER = 3'd2;
    localparam logic [2:0] A_STATUS = 3'd3;
    localparam logic [2:0] A_FCNT   = 3'd4;
    localparam logic [2:0] A_IRQEN  = 3'd5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_wr_en = 1'b0, cfg_rd_en = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [31:0] cfg_wdata = '0;
    logic        mon_tvalid = 1'b0, mon_tready = 1'b0, mon_tlast = 1'b0, mon_tuser = 1'b0;
    logic        tie0 = 1'b0;

    logic [31:0] cfg_rdata, frame_cnt;
    logic        cfg_rd_valid, active_bypass, core_enable, irq;
    logic [15:0] active_k1, active_cx, active_cy;

    logic [31:0] d_rdata, d_cnt;
    logic        d_rd_valid, d_byp, d_en, d_irq;
    logic [15:0] d_k1, d_cx, d_cy;

    always #5 clk = ~clk;

    bdc_frame_ctrl #(.WIDTH(W), .HEIGHT(H), .COORD_WIDTH(16),
                     .DEF_K1(16'h0200), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_wr_en(cfg_wr_en), .cfg_rd_en(cfg_rd_en), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .cfg_rd_valid(cfg_rd_valid),
        .mon_tvalid(mon_tvalid), .mon_tready(mon_tready),
        .mon_tlast(mon_tlast), .mon_tuser(mon_tuser),
        .active_k1(active_k1), .active_cx(active_cx), .active_cy(active_cy),
        .active_bypass(active_bypass), .core_enable(core_enable),
        .frame_cnt(frame_cnt), .irq(irq)
    );

    // Full-size instance, used only to confirm the default reset register values
    bdc_frame_ctrl dut_def (
        .clk(clk), .rst_n(rst_n),
        .cfg_wr_en(cfg_wr_en), .cfg_rd_en(cfg_rd_en), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_rdata(d_rdata), .cfg_rd_valid(d_rd_valid),
        .mon_tvalid(tie0), .mon_tready(tie0), .mon_tlast(tie0), .mon_tuser(tie0),
        .active_k1(d_k1), .active_cx(d_cx), .active_cy(d_cy),
        .active_bypass(d_byp), .core_enable(d_en),
        .frame_cnt(d_cnt), .irq(d_irq)
    );

    int          checks = 0;
    int          failures = 0;
    logic [5:0]  exp_status = '0;
    logic [5:0]  exp_irqen = '0;
    logic [31:0] exp_cnt = '0;
    logic [15:0] sh_k1 = 16'h0200, ex_k1 = 16'h0200;
    logic [15:0] sh_cx = 16'(W / 2), sh_cy = 16'(H / 2);
    logic [15:0] ex_cx = 16'(W / 2), ex_cy = 16'(H / 2);
    logic        sh_byp = 1'b0, ex_byp = 1'b0, sh_en = 1'b0;
    bit          pending_trunc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        cfg_wr_en = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_wr_en = 1'b0;
    endtask

    task automatic rdchk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        cfg_rd_en = 1'b1; cfg_addr = a;
        tick();
        cfg_rd_en = 1'b0;
        chk({tag, "_valid"}, {31'd0, cfg_rd_valid}, 32'd1);
        chk(tag, cfg_rdata, exp);
    endtask

    // One accepted beat, preceded by 0-2 cycles that carry no handshake
    task automatic send(input logic u, input logic l, input bit w1c_sof);
        int g;
        g = $urandom_range(0, 2);
        for (int i = 0; i < g; i++) begin
            mon_tvalid = 1'($urandom_range(0, 1));
            mon_tready = mon_tvalid ? 1'b0 : 1'($urandom_range(0, 1));
            mon_tuser  = 1'($urandom_range(0, 1));
            mon_tlast  = 1'($urandom_range(0, 1));
            tick();
        end
        mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tuser = u; mon_tlast = l;
        if (w1c_sof) begin
            cfg_wr_en = 1'b1; cfg_addr = A_STATUS; cfg_wdata = 32'h4;
        end
        tick();
        mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tuser = 1'b0; mon_tlast = 1'b0;
        cfg_wr_en = 1'b0;
    endtask

    // Model of an accepted start-of-frame
    task automatic on_sof(input bit w1c);
        if (w1c) exp_status &= ~6'h04;
        if (pending_trunc) begin
            exp_status |= 6'h04;
            pending_trunc = 0;
        end
        ex_k1 = sh_k1; ex_cx = sh_cx; ex_cy = sh_cy; ex_byp = sh_byp;
        chk("sof_k1", {16'd0, active_k1}, {16'd0, ex_k1});
        chk("sof_center", {active_cy, active_cx}, {ex_cy, ex_cx});
        chk("sof_bypass", {31'd0, active_bypass}, {31'd0, ex_byp});
    endtask

    // mode: 0 clean, 1 random short/long lines, 2 truncated, 3 clean + stray beats
    // opt : 0 plain (may write K1 mid-frame), 1 W1C on SOF, 2 disable mid-frame, 3 stall
    task automatic run_frame(input int mode, input int opt);
        int tl, tbeats, kind, len, k;
        bit first, dead;
        first = 1; dead = 0;
        tl = (mode == 2) ? $urandom_range(0, H - 1) : H;
        tbeats = (tl == 0) ? $urandom_range(1, W - 1) : $urandom_range(0, W - 1);
        for (int ln = 0; ln < H; ln++) begin
            if (ln == 1 && opt == 0 && $urandom_range(0, 1) == 1) begin
                sh_k1 = 16'($urandom);
                wr(A_K1, {16'd0, sh_k1});
                tick();
                chk("k1_hold_midframe", {16'd0, active_k1}, {16'd0, ex_k1});
            end
            if (ln == 2 && opt == 2) begin
                sh_en = 1'b0;
                wr(A_CTRL, {30'd0, sh_byp, 1'b0});
                chk("graceful_still_enabled", {31'd0, core_enable}, 32'd1);
            end
            if (ln == 1 && opt == 3) begin
                repeat (TO) tick();
`ifdef BDC_FRAME_TIMEOUT_EN
                exp_status |= 6'h20;
                dead = 1;
`endif
                rdchk("stall_status", A_STATUS, {26'd0, exp_status});
                chk("stall_frame_cnt", frame_cnt, exp_cnt);
            end
            if (ln == tl) begin
                for (int b = 0; b < tbeats; b++) begin
                    send(first, 1'b0, 1'b0);
                    if (first) on_sof(1'b0);
                    first = 0;
                end
                pending_trunc = 1;
                return;
            end
            kind = (mode == 1) ? $urandom_range(0, 2) : 0;
            len  = (kind == 1) ? $urandom_range(1, W - 1) : W;
            for (int b = 0; b < len; b++) begin
                send(first, (b == len - 1) && (kind != 2), first && (opt == 1));
                if (first) on_sof(opt == 1);
                first = 0;
            end
            if (dead)           exp_status |= 6'h08;
            else if (kind == 1) exp_status |= 6'h01;
            else if (kind == 2) exp_status |= 6'h02;
        end
        if (!dead) begin
            exp_status |= 6'h10;
            exp_cnt++;
        end
        if (opt == 2) chk("graceful_disabled", {31'd0, core_enable}, 32'd0);
        if (mode == 3) begin
            k = $urandom_range(1, 3);
            for (int i = 0; i < k; i++) send(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            exp_status |= 6'h08;
        end
    endtask

    task automatic check_regs();
        rdchk("status", A_STATUS, {26'd0, exp_status});
        rdchk("frame_cnt_reg", A_FCNT, exp_cnt);
        chk("frame_cnt_port", frame_cnt, exp_cnt);
        chk("irq", {31'd0, irq}, {31'd0, |(exp_status & exp_irqen)});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] e_small [8];
        logic [31:0] e_def   [8];
        logic [5:0]  m;
        int          mode;

        e_small = '{32'd0, 32'h200, {16'(H / 2), 16'(W / 2)}, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        e_def   = '{32'd0, 32'h200, 32'h021C03C0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};

        // Reset state
        #23;
        chk("rst_k1", {16'd0, active_k1}, 32'h200);
        chk("rst_center", {active_cy, active_cx}, {16'(H / 2), 16'(W / 2)});
        chk("rst_def_center", {d_cy, d_cx}, 32'h021C03C0);
        chk("rst_bypass", {31'd0, active_bypass}, 32'd0);
        chk("rst_core_enable", {31'd0, core_enable}, 32'd0);
        chk("rst_frame_cnt", frame_cnt, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_rdata", cfg_rdata, 32'd0);
        chk("rst_rd_valid", {31'd0, cfg_rd_valid}, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int a = 0; a < 8; a++) begin
            cfg_rd_en = 1'b1; cfg_addr = 3'(a);
            tick();
            chk($sformatf("rst_reg%0d", a), cfg_rdata, e_small[a]);
            chk($sformatf("rst_def_reg%0d", a), d_rdata, e_def[a]);
        end
        cfg_rd_en = 1'b0;
        tick();
        chk("rd_valid_drop", {31'd0, cfg_rd_valid}, 32'd0);

        // Unmapped write is ignored
        wr(3'd7, 32'hFFFF_FFFF);
        rdchk("unmapped", 3'd7, 32'd0);

        // Enable and two clean frames
        sh_en = 1'b1;
        wr(A_CTRL, 32'h1);
        tick();
        chk("enable_core", {31'd0, core_enable}, 32'd1);
        run_frame(0, 0);
        run_frame(0, 0);
        check_regs();
        chk("two_frames_status", {26'd0, exp_status}, 32'h10);
        exp_irqen = 6'h10;
        wr(A_IRQEN, 32'h10);
        tick();
        chk("irq_after_enable", {31'd0, irq}, 32'd1);
        wr(A_STATUS, 32'h10);
        exp_status &= ~6'h10;
        tick();
        chk("irq_after_w1c", {31'd0, irq}, 32'd0);

        // Truncated frame, then SOF coinciding with a W1C of short_frame
        run_frame(2, 0);
        run_frame(0, 1);
        check_regs();

        // Malformed lines, then a mid-frame stall
        run_frame(1, 0);
        run_frame(1, 0);
        check_regs();
        run_frame(0, 3);
        check_regs();

        // Graceful stop, beats while disabled are ignored
        run_frame(0, 2);
        check_regs();
        for (int i = 0; i < 3; i++) send(1'b1, 1'b0, 1'b0);
        check_regs();
        sh_en = 1'b1;
        wr(A_CTRL, {30'd0, sh_byp, 1'b1});

        // Counter clear (self-clearing bit)
        wr(A_CTRL, {29'd0, 1'b1, sh_byp, 1'b1});
        exp_cnt = '0;
        chk("clr_cnt", frame_cnt, 32'd0);
        rdchk("ctrl_readback", A_CTRL, {30'd0, sh_byp, 1'b1});

        // Randomized frames and config traffic
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                sh_cx = 16'($urandom); sh_cy = 16'($urandom);
                wr(A_CENTER, {sh_cy, sh_cx});
            end
            if ($urandom_range(0, 2) == 0) begin
                sh_byp = 1'($urandom_range(0, 1));
                wr(A_CTRL, {30'd0, sh_byp, 1'b1});
            end
            mode = $urandom_range(0, 3);
            run_frame(mode, 0);
            check_regs();
            if ($urandom_range(0, 2) == 0) begin
                m = 6'($urandom);
                wr(A_STATUS, {26'd0, m});
                exp_status &= ~m;
            end
            if ($urandom_range(0, 3) == 0) begin
                exp_irqen = 6'($urandom);
                wr(A_IRQEN, {26'd0, exp_irqen});
            end
        end
        if (pending_trunc) run_frame(0, 0);
        check_regs();
        rdchk("irqen_readback", A_IRQEN, {26'd0, exp_irqen});
        rdchk("k1_readback", A_K1, {16'd0, sh_k1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
